// File: rtl/merger_ctrl_pkg.sv
// Shared FSM encoding and AXI beat/burst sizing for the read-burst arbiter.
package merger_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_DRAIN
  } state_e;

  localparam int unsigned BEAT_BYTES  = 64;
  localparam int unsigned BEAT_SHIFT  = $clog2(BEAT_BYTES);
  localparam int unsigned BURST_BYTES = 16 * BEAT_BYTES;

endpackage

// File: rtl/rr_select.sv
// Round-robin priority pick: first asserted request at or after ptr_i, wrapping.
module rr_select #(
  parameter int N   = 16,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] grant_o,
  output logic           any_o
);

  localparam int unsigned NU = N;

  logic [IDW-1:0] idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      idx = IDW'((32'(ptr_i) + i) % NU);
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/axi_rd_burst_arbiter.sv
// Shares one AXI AR port among per-channel readers: round-robin, credit-limited
// burst issue, with done raised only after every issued burst has been drained.
module axi_rd_burst_arbiter
  import merger_ctrl_pkg::*;
#(
  parameter int C_NUM_CHANNELS     = 16,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_BURST_LEN        = 16,
  parameter int C_MAX_OUTSTANDING  = 2,
  localparam int ID_W = (C_NUM_CHANNELS > 1) ? $clog2(C_NUM_CHANNELS) : 1
) (
  input  logic                                         aclk,
  input  logic                                         areset,
  input  logic                                         ctrl_start,
  input  logic [C_NUM_CHANNELS*C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]                 ctrl_xfer_size_in_bytes,
  output logic                                         ctrl_done,
  output logic                                         m_axi_arvalid,
  input  logic                                         m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                m_axi_araddr,
  output logic [7:0]                                   m_axi_arlen,
  output logic                                         ar_ch_valid,
  output logic [ID_W-1:0]                              ar_ch_id,
  input  logic [C_NUM_CHANNELS-1:0]                    burst_consumed
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam int CW = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int unsigned NU = C_NUM_CHANNELS;

  state_e state_q, state_d;
  logic   done_q, done_d;

  logic [AW-1:0]   base_q   [C_NUM_CHANNELS];
  logic [XW-1:0]   rem_q    [C_NUM_CHANNELS];
  logic [XW-1:0]   off_q    [C_NUM_CHANNELS];
  logic [CW-1:0]   credit_q [C_NUM_CHANNELS];
  logic [ID_W-1:0] rr_ptr_q;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [ID_W-1:0] ch_id_q;

  logic [C_NUM_CHANNELS-1:0] eligible;
  logic                      any_rem;
  logic                      all_full;
  logic [ID_W-1:0]           grant;
  logic                      grant_any;
  logic                      hs;
  logic [XW-1:0]             rem_beats, burst_beats;
  logic [XW-1:0]             hs_bytes;
  logic [XW-1:0]             size_rnd;
  logic [ID_W-1:0]           rr_next;

  always_comb begin
    eligible = '0;
    any_rem  = 1'b0;
    all_full = 1'b1;
    for (int unsigned c = 0; c < NU; c++) begin
      eligible[c] = (rem_q[c] != '0) && (credit_q[c] != '0);
      any_rem     = any_rem | (rem_q[c] != '0);
      all_full    = all_full & (credit_q[c] == CW'(C_MAX_OUTSTANDING));
    end
  end

  rr_select #(
    .N   (C_NUM_CHANNELS),
    .IDW (ID_W)
  ) u_rr_select (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .any_o   (grant_any)
  );

  always_comb begin
    rem_beats   = rem_q[grant] >> BEAT_SHIFT;
    burst_beats = (rem_beats > XW'(C_BURST_LEN)) ? XW'(C_BURST_LEN) : rem_beats;
    arlen_d     = 8'(burst_beats - 1'b1);
    araddr_d    = base_q[grant] + AW'(off_q[grant]);
  end

  // Reset masks arvalid in the same cycle so no handshake can complete under reset.
  assign m_axi_arvalid = (state_q == ST_ISSUE) && !areset;
  assign hs            = m_axi_arvalid && m_axi_arready;
  assign ar_ch_valid   = hs;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign ar_ch_id      = ch_id_q;
  assign ctrl_done     = done_q;

  assign hs_bytes = XW'({1'b0, arlen_q} + 9'd1) << BEAT_SHIFT;
  assign size_rnd = (ctrl_xfer_size_in_bytes + XW'(BEAT_BYTES - 1)) & ~XW'(BEAT_BYTES - 1);
  assign rr_next  = (ch_id_q == ID_W'(C_NUM_CHANNELS - 1)) ? '0 : ch_id_q + 1'b1;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (ctrl_start) state_d = ST_ARB;
      ST_ARB: begin
        if (grant_any)     state_d = ST_ISSUE;
        else if (!any_rem) state_d = ST_DRAIN;
      end
      ST_ISSUE: if (m_axi_arready) state_d = ST_ARB;
      ST_DRAIN: begin
        if (all_full) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr_q <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      ch_id_q  <= '0;
      for (int unsigned c = 0; c < NU; c++) begin
        base_q[c]   <= '0;
        rem_q[c]    <= '0;
        off_q[c]    <= '0;
        credit_q[c] <= CW'(C_MAX_OUTSTANDING);
      end
    end else begin
      if (state_q == ST_IDLE && ctrl_start) begin
        for (int unsigned c = 0; c < NU; c++) begin
          base_q[c] <= ctrl_addr_offset[c*AW +: AW];
          rem_q[c]  <= size_rnd;
          off_q[c]  <= '0;
        end
      end
      if (state_q == ST_ARB && grant_any) begin
        araddr_q <= araddr_d;
        arlen_q  <= arlen_d;
        ch_id_q  <= grant;
      end
      if (hs) begin
        rem_q[ch_id_q] <= rem_q[ch_id_q] - hs_bytes;
        off_q[ch_id_q] <= off_q[ch_id_q] + hs_bytes;
        rr_ptr_q       <= rr_next;
      end
      // A consume coinciding with this channel's handshake cancels out.
      for (int unsigned c = 0; c < NU; c++) begin
        if (hs && ch_id_q == ID_W'(c) && !burst_consumed[c])
          credit_q[c] <= credit_q[c] - 1'b1;
        else if (burst_consumed[c] && !(hs && ch_id_q == ID_W'(c)) &&
                 credit_q[c] != CW'(C_MAX_OUTSTANDING))
          credit_q[c] <= credit_q[c] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_arbiter.sv
// Directed and randomized bench for axi_rd_burst_arbiter with a per-channel burst-list model.
module tb_axi_rd_burst_arbiter;

  localparam int NCH = 16;
  localparam int AW  = 64;
  localparam int XW  = 32;
  localparam int BL  = 16;
  localparam int MO  = 2;

  logic              aclk;
  logic              areset;
  logic              ctrl_start;
  logic [NCH*AW-1:0] ctrl_addr_offset;
  logic [XW-1:0]     ctrl_xfer_size_in_bytes;
  logic              ctrl_done;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [AW-1:0]     m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic              ar_ch_valid;
  logic [3:0]        ar_ch_id;
  logic [NCH-1:0]    burst_consumed;

  axi_rd_burst_arbiter #(
    .C_NUM_CHANNELS     (NCH),
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_XFER_SIZE_WIDTH  (XW),
    .C_BURST_LEN        (BL),
    .C_MAX_OUTSTANDING  (MO)
  ) dut (
    .aclk                    (aclk),
    .areset                  (areset),
    .ctrl_start              (ctrl_start),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_done               (ctrl_done),
    .m_axi_arvalid           (m_axi_arvalid),
    .m_axi_arready           (m_axi_arready),
    .m_axi_araddr            (m_axi_araddr),
    .m_axi_arlen             (m_axi_arlen),
    .ar_ch_valid             (ar_ch_valid),
    .ar_ch_id                (ar_ch_id),
    .burst_consumed          (burst_consumed)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
  int ready_pct = 100, cons_pct = 0;
  logic [NCH-1:0] force_cons = '0;

  logic [AW-1:0]   m_base [NCH];
  longint unsigned m_rem  [NCH];
  longint unsigned m_off  [NCH];
  int              outst  [NCH];
  bit              run_active = 0;

  int            q_ch[$];
  logic [AW-1:0] q_addr[$];
  int            q_len[$];
  int            q_cyc[$];

  logic          prev_valid = 0, prev_hs = 0, prev_rst = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_len = '0;
  logic [3:0]    prev_id = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic tick(input logic start, input logic rst);
    logic [NCH-1:0] cons;
    @(posedge aclk);
    #1;
    cyc++;
    areset        = rst;
    ctrl_start    = start;
    m_axi_arready = ($urandom_range(99) < ready_pct);
    cons = '0;
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (outst[c] > 0 && (force_cons[c] || $urandom_range(99) < cons_pct)) begin
          cons[c] = 1'b1;
          outst[c]--;
        end
      end
    end
    force_cons     = '0;
    burst_consumed = cons;
    if (rst) begin
      run_active = 0;
      for (int c = 0; c < NCH; c++) begin
        outst[c] = 0;
        m_rem[c] = 0;
        m_off[c] = 0;
      end
    end else if (start) begin
      run_active = 1;
      start_cyc  = cyc;
      for (int c = 0; c < NCH; c++) begin
        m_rem[c] = ((64'(ctrl_xfer_size_in_bytes) + 63) / 64) * 64;
        m_off[c] = 0;
      end
    end
    @(negedge aclk);
    if (ar_ch_valid === 1'b1) begin
      int ch;
      longint unsigned beats, exp_len;
      ch = int'(ar_ch_id);
      chk("hs_arvalid", m_axi_arvalid, 1);
      chk("hs_has_work", (m_rem[ch] != 0), 1);
      beats = m_rem[ch] / 64;
      if (beats > BL) beats = BL;
      exp_len = (beats == 0) ? 0 : beats - 1;
      chk("araddr", m_axi_araddr, m_base[ch] + m_off[ch]);
      chk("arlen", m_axi_arlen, exp_len);
      m_rem[ch] -= beats * 64;
      m_off[ch] += beats * 64;
      outst[ch]++;
      chk("credit_limit", (outst[ch] <= MO), 1);
      q_ch.push_back(ch);
      q_addr.push_back(m_axi_araddr);
      q_len.push_back(int'(m_axi_arlen));
      q_cyc.push_back(cyc);
    end
    if (prev_valid && !prev_hs && !rst && !prev_rst) begin
      chk("hold_arvalid", m_axi_arvalid, 1);
      chk("hold_araddr", m_axi_araddr, prev_addr);
      chk("hold_arlen", m_axi_arlen, prev_len);
      chk("hold_id", ar_ch_id, prev_id);
    end
    if (ctrl_done === 1'b1) begin
      int tot;
      longint unsigned rtot;
      tot = 0;
      rtot = 0;
      for (int c = 0; c < NCH; c++) begin
        tot += outst[c];
        rtot += m_rem[c];
      end
      done_cnt++;
      done_cyc = cyc;
      chk("done_in_run", run_active, 1);
      chk("done_drained", (tot == 0 && rtot == 0), 1);
      run_active = 0;
    end
    prev_valid = m_axi_arvalid;
    prev_hs    = ar_ch_valid;
    prev_addr  = m_axi_araddr;
    prev_len   = m_axi_arlen;
    prev_id    = ar_ch_id;
    prev_rst   = rst;
  endtask

  task automatic start_run(input int unsigned size);
    for (int c = 0; c < NCH; c++) begin
      m_base[c] = {$urandom, $urandom} & ~64'h3FF;
      ctrl_addr_offset[c*AW +: AW] = m_base[c];
    end
    ctrl_xfer_size_in_bytes = size;
    q_ch.delete();
    q_addr.delete();
    q_len.delete();
    q_cyc.delete();
    tick(1, 0);
  endtask

  task automatic wait_done(input int budget);
    int n, d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick(0, 0);
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  function automatic int find_rec(input int ch, input int nth);
    int n;
    n = 0;
    foreach (q_ch[i]) begin
      if (q_ch[i] == ch) begin
        if (n == nth) return i;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic int count_ch(input int ch);
    int n;
    n = 0;
    foreach (q_ch[i]) if (q_ch[i] == ch) n++;
    return n;
  endfunction

  initial begin
    int d0, idx, vcnt;
    int unsigned sz;
    areset = 1'b1;
    ctrl_start = 1'b0;
    m_axi_arready = 1'b0;
    burst_consumed = '0;
    ctrl_addr_offset = '0;
    ctrl_xfer_size_in_bytes = '0;
    for (int c = 0; c < NCH; c++) begin
      m_base[c] = '0;
      m_rem[c] = 0;
      m_off[c] = 0;
      outst[c] = 0;
    end

    // Reset state
    repeat (3) tick(0, 1);
    tick(0, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_chvalid", ar_ch_valid, 0);
    chk("rst_chid", ar_ch_id, 0);
    chk("rst_done", ctrl_done, 0);

    // Size 2048, always ready, immediate consume
    ready_pct = 100;
    cons_pct = 100;
    d0 = done_cnt;
    start_run(2048);
    wait_done(400);
    repeat (5) tick(0, 0);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_ar_count", q_ch.size(), 32);
    if (q_cyc.size() > 0) chk("t1_latency", q_cyc[0] - start_cyc, 2);
    idx = find_rec(0, 0);
    chk("t1_ch0_first", (idx >= 0), 1);
    if (idx >= 0) begin
      chk("t1_ch0_addr0", q_addr[idx], m_base[0]);
      chk("t1_ch0_len0", q_len[idx], 15);
    end
    idx = find_rec(0, 1);
    chk("t1_ch0_second", (idx >= 0), 1);
    if (idx >= 0) begin
      chk("t1_ch0_addr1", q_addr[idx], m_base[0] + 64'd1024);
      chk("t1_ch0_len1", q_len[idx], 15);
    end
    for (int i = 1; i < q_cyc.size(); i++)
      chk("t1_spacing", (q_cyc[i] - q_cyc[i-1] >= 2), 1);

    // Size 1024: one burst per channel in strict round-robin order
    start_run(1024);
    wait_done(400);
    chk("t2_ar_count", q_ch.size(), 16);
    for (int i = 0; i < q_ch.size(); i++) chk("t2_order", q_ch[i], (i % NCH));

    // Size 1088: full burst then a single-beat tail
    start_run(1088);
    wait_done(400);
    chk("t3_ar_count", q_ch.size(), 32);
    idx = find_rec(0, 1);
    chk("t3_ch0_second", (idx >= 0), 1);
    if (idx >= 0) begin
      chk("t3_tail_len", q_len[idx], 0);
      chk("t3_tail_addr", q_addr[idx], m_base[0] + 64'd1024);
    end

    // Size 4096 without consumes: credit stall, then one AR per consume
    cons_pct = 0;
    start_run(4096);
    repeat (120) tick(0, 0);
    chk("t4_stall_count", q_ch.size(), 32);
    for (int c = 0; c < NCH; c++) chk("t4_per_ch", count_ch(c), 2);
    force_cons[5] = 1'b1;
    repeat (12) tick(0, 0);
    chk("t4_release_count", q_ch.size(), 33);
    if (q_ch.size() == 33) chk("t4_release_ch", q_ch[32], 5);

    // arready low for 10 cycles, then handshake coinciding with a consume
    ready_pct = 0;
    force_cons[9] = 1'b1;
    tick(0, 0);
    vcnt = 0;
    repeat (11) begin
      tick(0, 0);
      if (m_axi_arvalid === 1'b1) vcnt++;
    end
    chk("t5_valid_cycles", vcnt, 10);
    chk("t5_held_addr", m_axi_araddr, m_base[9] + 64'd2048);
    chk("t5_held_len", m_axi_arlen, 15);
    ready_pct = 100;
    force_cons[9] = 1'b1;
    tick(0, 0);
    repeat (12) tick(0, 0);
    chk("t5_count", q_ch.size(), 35);
    if (q_ch.size() == 35) chk("t5_last_ch", q_ch[34], 9);
    cons_pct = 50;
    wait_done(3000);

    // Reset while an AR is pending
    ready_pct = 0;
    cons_pct = 0;
    start_run(2048);
    tick(0, 0);
    tick(0, 0);
    chk("t6_pending", m_axi_arvalid, 1);
    ready_pct = 100;
    d0 = done_cnt;
    tick(0, 1);
    chk("t6_no_hs", ar_ch_valid, 0);
    tick(0, 0);
    chk("t6_arvalid", m_axi_arvalid, 0);
    chk("t6_araddr", m_axi_araddr, 0);
    chk("t6_arlen", m_axi_arlen, 0);
    chk("t6_chid", ar_ch_id, 0);
    repeat (4) tick(0, 0);
    chk("t6_no_done", done_cnt - d0, 0);

    // Size 0 after reset: done three cycles after start, no AR
    start_run(0);
    wait_done(10);
    chk("t6_zero_latency", done_cyc - start_cyc, 3);
    chk("t6_zero_ars", q_ch.size(), 0);

    // Fresh run after reset starts from channel 0
    cons_pct = 100;
    start_run(1024);
    wait_done(400);
    if (q_ch.size() > 0) begin
      chk("t6_first_ch", q_ch[0], 0);
      chk("t6_latency", q_cyc[0] - start_cyc, 2);
    end

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      sz = $urandom_range(0, 3000);
      ready_pct = $urandom_range(40, 100);
      cons_pct = $urandom_range(20, 80);
      start_run(sz);
      wait_done(4000);
      chk("rand_ar_count", q_ch.size(), NCH * ((sz + 1023) / 1024));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_burst_arbiter.md
AXI_RD_BURST_ARBITER -- requirements
Module: axi_rd_burst_arbiter

Interface
REQ-001 SHALL have parameter C_NUM_CHANNELS, default 16: number of read channels (merger leaves) sharing one AR port.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64: AXI address width.
REQ-003 SHALL have parameter C_XFER_SIZE_WIDTH, default 32: per-channel byte-count width.
REQ-004 SHALL have parameter C_BURST_LEN, default 16: maximum beats per burst, 64-byte beats (1024-byte bursts).
REQ-005 SHALL have parameter C_MAX_OUTSTANDING, default 2: per-channel burst credits, equal to channel FIFO depth 32 / C_BURST_LEN.
REQ-006 SHALL have ports, clock and reset first:
- aclk  in  1  sole clock; single clock domain.
- areset  in  1  synchronous, active-high reset.
- ctrl_start  in  1  one-cycle pulse; load a new run set.
- ctrl_addr_offset  in  C_NUM_CHANNELS x C_M_AXI_ADDR_WIDTH  per-channel base byte address, 1024-aligned.
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  bytes per channel, same for all channels.
- ctrl_done  out  1  one-cycle pulse; all bursts issued and consumed.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  burst address.
- m_axi_arlen  out  8  beats minus one.
- ar_ch_valid  out  1  pulse on AR handshake; pushes channel index into the read-data routing FIFO.
- ar_ch_id  out  $clog2(C_NUM_CHANNELS)  channel of the handshaken burst.
- burst_consumed  in  C_NUM_CHANNELS  per-channel pulse; one burst drained from that channel's FIFO.

Function
REQ-007 SHALL implement states IDLE, ARB, ISSUE, DRAIN.
REQ-008 IDLE: on ctrl_start, latch bases, set each channel's remaining bytes to ctrl_xfer_size_in_bytes rounded up to a multiple of 64, set burst offset to 0, then go to ARB.
REQ-009 ctrl_start outside IDLE SHALL be ignored.
REQ-010 Channel eligible = remaining > 0 AND credit > 0.
REQ-011 ARB: round-robin grant to the first eligible channel at or after rr_ptr (wrap C_NUM_CHANNELS-1 -> 0). Register araddr, arlen, and ch_id. Go to ISSUE next cycle.
REQ-012 ARB with no eligible channel:
- some remaining > 0: stay in ARB (credit-starved);
- none remaining: go to DRAIN.
REQ-013 ISSUE: m_axi_arvalid = 1, and araddr/arlen/ar_ch_id SHALL stay stable until m_axi_arready.
REQ-014 On the ISSUE handshake cycle:
- ar_ch_valid = 1;
- granted channel: remaining -= beats*64, offset += beats*64, credit -= 1;
- rr_ptr = granted + 1 (wrapped);
- next state ARB.
REQ-015 araddr = base + offset. arlen = min(C_BURST_LEN, remaining/64) - 1. The last burst may be short.
REQ-016 Credit SHALL:
- +1 on burst_consumed;
- -1 on handshake;
- stay unchanged if both occur in the same cycle.
REQ-017 Credit SHALL saturate at C_MAX_OUTSTANDING; burst_consumed at max credit is ignored.
REQ-018 DRAIN: when all credits equal C_MAX_OUTSTANDING, pulse ctrl_done for 1 cycle and go to IDLE.
REQ-019 ctrl_xfer_size_in_bytes = 0: no AR issued, and ctrl_done SHALL pulse 3 cycles after ctrl_start (IDLE -> ARB -> DRAIN -> done).
REQ-020 Latency: ctrl_start at cycle t gives first m_axi_arvalid at t+2. Minimum handshake-to-next-arvalid spacing is 2 cycles.
REQ-021 Arithmetic: offset and remaining in C_XFER_SIZE_WIDTH bits; address add in C_M_AXI_ADDR_WIDTH bits. A 1024-aligned base guarantees no 4 KB crossing.

Reset
REQ-022 areset SHALL force state IDLE, rr_ptr 0, all credits C_MAX_OUTSTANDING, remaining 0, and all outputs 0.
REQ-023 areset mid-burst SHALL drop arvalid in the next cycle without completing the handshake, and SHALL not emit ctrl_done.

Structure
REQ-024 State enum, beat bytes (64) and burst-bytes constant SHALL live in shared package merger_ctrl_pkg.
REQ-025 Round-robin priority selection SHALL be one sub-module, rr_select (request vector + pointer -> grant index + any).

Verification
REQ-026 Single channel, size 2048, arready=1, immediate consume:
- 2 ARs, araddr base and base+1024, arlen 15;
- ctrl_done pulses once.
REQ-027 16 channels, size 1024, arready=1: ar_ch_id order 0,1,...,15; no channel granted twice.
REQ-028 Size 1088, one channel: arlen 15 then arlen 0 at base+1024.
REQ-029 No burst_consumed, size 4096, one channel:
- exactly 2 ARs, then stall in ARB;
- each later burst_consumed pulse releases exactly one further AR.
REQ-030 arready held low 10 cycles: arvalid, araddr, arlen stable for all 10 cycles. Simultaneous burst_consumed and handshake leave credit unchanged.
REQ-031 areset asserted mid-ISSUE: outputs 0 next cycle. New ctrl_start then behaves as after power-up. Size 0 gives ctrl_done at t+3 with no AR.
